// File: rtl/btb_predict_ctrl_pkg.sv
// Shared types for the fetch-side BTB predictor: BTB read/update buses,
// in-flight prediction record and controller state.
package btb_predict_ctrl_pkg;

   localparam int ADDR_WIDTH = 32;
   localparam int BTB_SIZE   = 16;

   typedef struct packed {
      logic [ADDR_WIDTH-1:0] i_addr;
      logic [ADDR_WIDTH-1:0] target_addr;
   } btb_entry_t;

   typedef struct packed {
      logic [ADDR_WIDTH-1:0] i_addr;
      logic [ADDR_WIDTH-1:0] branch_target;
      logic                  is_taken;
   } br_cntrl_bus_t;

   // btb_cntrl clears on is_taken=0, so "no update" must keep is_taken high
   localparam br_cntrl_bus_t BR_CNTRL_IDLE = '{i_addr: '0, branch_target: '0, is_taken: 1'b1};

   typedef struct packed {
      logic [ADDR_WIDTH-1:0] pc;
      logic                  pred_taken;
      logic [ADDR_WIDTH-1:0] next_pc;
   } bpu_fifo_entry_t;

   typedef enum logic {RUN, FLUSH} bpu_state_e;

endpackage

// File: rtl/btb_predict_ctrl_if.sv
// Fetch, resolve, redirect and BTB-side signals of the predictor.
// master = core/BTB environment, slave = btb_predict_ctrl.
interface btb_predict_ctrl_if;
   import btb_predict_ctrl_pkg::*;

   logic                  fetch_valid_i;
   logic [ADDR_WIDTH-1:0] fetch_pc_i;
   logic                  stall_o;
   logic [ADDR_WIDTH-1:0] btb_raddr_o;
   btb_entry_t            btb_entry_i;
   logic                  pred_taken_o;
   logic [ADDR_WIDTH-1:0] next_pc_o;
   logic                  res_valid_i;
   logic                  res_is_branch_i;
   logic                  res_taken_i;
   logic [ADDR_WIDTH-1:0] res_target_i;
   logic                  redirect_o;
   logic [ADDR_WIDTH-1:0] redirect_pc_o;
   br_cntrl_bus_t         br_cntrl_o;
   logic                  is_branch_o;
   logic                  err_o;

   modport master (
      output fetch_valid_i, fetch_pc_i, btb_entry_i,
             res_valid_i, res_is_branch_i, res_taken_i, res_target_i,
      input  stall_o, btb_raddr_o, pred_taken_o, next_pc_o,
             redirect_o, redirect_pc_o, br_cntrl_o, is_branch_o, err_o
   );

   modport slave (
      input  fetch_valid_i, fetch_pc_i, btb_entry_i,
             res_valid_i, res_is_branch_i, res_taken_i, res_target_i,
      output stall_o, btb_raddr_o, pred_taken_o, next_pc_o,
             redirect_o, redirect_pc_o, br_cntrl_o, is_branch_o, err_o
   );

endinterface

// File: rtl/bpu_inflight_fifo.sv
// In-order queue of outstanding predictions; head is read combinationally.
// flush_i empties the queue and wins over push/pop.
module bpu_inflight_fifo
   import btb_predict_ctrl_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        flush_i,
   input  logic                        push_i,
   input  bpu_fifo_entry_t             din_i,
   input  logic                        pop_i,
   output bpu_fifo_entry_t             head_o,
   output logic [$clog2(DEPTH):0]      count_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   bpu_fifo_entry_t    mem_q [DEPTH];
   bpu_fifo_entry_t    mem_d [DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               pop_ok, push_ok;

   // a pop in the same cycle frees the slot a full-queue push lands in
   assign pop_ok  = pop_i && (cnt_q != '0);
   assign push_ok = push_i && ((cnt_q != CNT_W'(DEPTH)) || pop_ok);

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         cnt_d    = '0;
      end else begin
         if (push_ok) begin
            mem_d[wr_ptr_q] = din_i;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
         end
         if (pop_ok) rd_ptr_d = rd_ptr_q + PTR_W'(1);
         if (push_ok && !pop_ok) cnt_d = cnt_q + CNT_W'(1);
         else if (!push_ok && pop_ok) cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = cnt_q;

endmodule

// File: rtl/btb_predict_ctrl.sv
// Fetch-side BTB lookup plus in-order resolution check: raises redirects on
// mispredicts and drives the btb_cntrl update bus one cycle after each pop.
module btb_predict_ctrl
   import btb_predict_ctrl_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int BTB_IDX_W  = $clog2(BTB_SIZE)
) (
   input logic             clk,
   input logic             rst_n,
   btb_predict_ctrl_if.slave bus
);

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   bpu_state_e            state_q, state_d;
   br_cntrl_bus_t         br_q, br_d;
   logic                  is_br_q, is_br_d;
   logic [ADDR_WIDTH-1:0] redir_pc_q, redir_pc_d;
   logic                  err_q, err_d;

   bpu_fifo_entry_t       head, push_entry;
   logic [CNT_W-1:0]      count;
   logic                  hit, stall, run, fifo_empty, push, pop, mispredict;
   logic [ADDR_WIDTH-1:0] pc_plus4, pred_next, actual_next;

   assign hit        = (bus.btb_entry_i.i_addr == bus.fetch_pc_i) &&
                       (bus.btb_entry_i.target_addr != '0);
   assign pc_plus4   = bus.fetch_pc_i + ADDR_WIDTH'(4);
   assign pred_next  = hit ? bus.btb_entry_i.target_addr : pc_plus4;
   assign stall      = (count == CNT_W'(FIFO_DEPTH));
   assign fifo_empty = (count == '0);
   assign run        = (state_q == RUN);
   assign pop        = bus.res_valid_i && run && !fifo_empty;
   assign push       = bus.fetch_valid_i && run && (!stall || pop);

   assign actual_next = bus.res_taken_i ? bus.res_target_i : head.pc + ADDR_WIDTH'(4);
   assign mispredict  = pop && (actual_next != head.next_pc);

   assign push_entry = '{pc: bus.fetch_pc_i, pred_taken: hit, next_pc: pred_next};

   bpu_inflight_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush_i (mispredict),
      .push_i  (push),
      .din_i   (push_entry),
      .pop_i   (pop),
      .head_o  (head),
      .count_o (count)
   );

   always_comb begin
      state_d    = state_q;
      br_d       = BR_CNTRL_IDLE;
      is_br_d    = 1'b0;
      redir_pc_d = redir_pc_q;
      err_d      = err_q;
      case (state_q)
         RUN: begin
            if (bus.res_valid_i && fifo_empty) err_d = 1'b1;
            if (pop) begin
               if (bus.res_is_branch_i) begin
                  is_br_d = 1'b1;
                  br_d    = bus.res_taken_i ?
                            '{i_addr: head.pc, branch_target: bus.res_target_i, is_taken: 1'b1} :
                            '{i_addr: head.pc, branch_target: '0, is_taken: 1'b0};
               end else if (head.pred_taken) begin
                  // non-branch aliased onto a BTB entry: scrub it
                  br_d = '{i_addr: head.pc, branch_target: '0, is_taken: 1'b0};
               end
               if (mispredict) begin
                  state_d    = FLUSH;
                  redir_pc_d = actual_next;
               end
            end
         end
         FLUSH:   state_d = RUN;
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= RUN;
         br_q       <= BR_CNTRL_IDLE;
         is_br_q    <= 1'b0;
         redir_pc_q <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         br_q       <= br_d;
         is_br_q    <= is_br_d;
         redir_pc_q <= redir_pc_d;
         err_q      <= err_d;
      end
   end

   assign bus.stall_o       = stall;
   assign bus.btb_raddr_o   = {{(ADDR_WIDTH-BTB_IDX_W){1'b0}}, bus.fetch_pc_i[BTB_IDX_W+1:2]};
   assign bus.pred_taken_o  = bus.fetch_valid_i && hit;
   assign bus.next_pc_o     = pred_next;
   assign bus.redirect_o    = (state_q == FLUSH);
   assign bus.redirect_pc_o = redir_pc_q;
   assign bus.br_cntrl_o    = br_q;
   assign bus.is_branch_o   = is_br_q;
   assign bus.err_o         = err_q;

endmodule

// File: tb/tb_btb_predict_ctrl.sv
// Directed bench for btb_predict_ctrl with a behavioural btb_cntrl model
// feeding btb_entry_i from the update bus.
module tb_btb_predict_ctrl;
   import btb_predict_ctrl_pkg::*;

   localparam int IDX_W = $clog2(BTB_SIZE);

   logic clk;
   logic rst_n;
   logic tb_init;
   int   total;
   int   bad;

   btb_predict_ctrl_if bus();

   btb_predict_ctrl #(.FIFO_DEPTH(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // btb_cntrl model: clear on is_taken=0, write on is_taken & is_branch
   logic [ADDR_WIDTH-1:0] m_ia [BTB_SIZE];
   logic [ADDR_WIDTH-1:0] m_tg [BTB_SIZE];
   logic [IDX_W-1:0]      widx, ridx;
   assign widx = bus.br_cntrl_o.i_addr[IDX_W+1:2];
   assign ridx = bus.btb_raddr_o[IDX_W-1:0];

   always @(posedge clk) begin
      if (tb_init) begin
         for (int i = 0; i < BTB_SIZE; i++) begin
            m_ia[i] <= '0;
            m_tg[i] <= '0;
         end
      end else if (!bus.br_cntrl_o.is_taken) begin
         m_ia[widx] <= '0;
         m_tg[widx] <= '0;
      end else if (bus.is_branch_o) begin
         m_ia[widx] <= bus.br_cntrl_o.i_addr;
         m_tg[widx] <= bus.br_cntrl_o.branch_target;
      end
   end

   always_comb bus.btb_entry_i = '{i_addr: m_ia[ridx], target_addr: m_tg[ridx]};

   function automatic br_cntrl_bus_t mk_br(input logic [31:0] a, input logic [31:0] t, input logic k);
      mk_br = '{i_addr: a, branch_target: t, is_taken: k};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      bus.fetch_valid_i   = 1'b0;
      bus.fetch_pc_i      = '0;
      bus.res_valid_i     = 1'b0;
      bus.res_is_branch_i = 1'b0;
      bus.res_taken_i     = 1'b0;
      bus.res_target_i    = '0;
   endtask

   task automatic fetch(input logic [31:0] pc);
      bus.fetch_valid_i = 1'b1;
      bus.fetch_pc_i    = pc;
   endtask

   task automatic resolve(input logic br, input logic tk, input logic [31:0] tgt);
      bus.res_valid_i     = 1'b1;
      bus.res_is_branch_i = br;
      bus.res_taken_i     = tk;
      bus.res_target_i    = tgt;
   endtask

   task automatic test_reset();
      br_cntrl_bus_t e;
      e = mk_br(32'h0, 32'h0, 1'b1);
      rst_n = 1'b0; tb_init = 1'b1; idle_in();
      step(); step();
      total++; if (bus.redirect_o !== 1'b0) begin bad++; $display("FAIL rst_redirect got=%b exp=0", bus.redirect_o); end
      total++; if (bus.redirect_pc_o !== 32'h0) begin bad++; $display("FAIL rst_redirect_pc got=%h exp=0", bus.redirect_pc_o); end
      total++; if (bus.br_cntrl_o !== e) begin bad++; $display("FAIL rst_br got=%h exp=%h", bus.br_cntrl_o, e); end
      total++; if (bus.is_branch_o !== 1'b0) begin bad++; $display("FAIL rst_is_branch got=%b exp=0", bus.is_branch_o); end
      total++; if (bus.err_o !== 1'b0) begin bad++; $display("FAIL rst_err got=%b exp=0", bus.err_o); end
      total++; if (bus.stall_o !== 1'b0) begin bad++; $display("FAIL rst_stall got=%b exp=0", bus.stall_o); end
      tb_init = 1'b0;
      rst_n   = 1'b1;
      step();
   endtask

   task automatic test_cold_taken();
      br_cntrl_bus_t e;
      fetch(32'h100); #1;
      total++; if (bus.pred_taken_o !== 1'b0) begin bad++; $display("FAIL cold_pred got=%b exp=0", bus.pred_taken_o); end
      total++; if (bus.next_pc_o !== 32'h104) begin bad++; $display("FAIL cold_next got=%h exp=104", bus.next_pc_o); end
      total++; if (bus.btb_raddr_o !== 32'h0) begin bad++; $display("FAIL cold_raddr got=%h exp=0", bus.btb_raddr_o); end
      step();
      idle_in(); resolve(1'b1, 1'b1, 32'h200);
      step();
      idle_in();
      e = mk_br(32'h100, 32'h200, 1'b1);
      total++; if (bus.redirect_o !== 1'b1) begin bad++; $display("FAIL t1_redirect got=%b exp=1", bus.redirect_o); end
      total++; if (bus.redirect_pc_o !== 32'h200) begin bad++; $display("FAIL t1_redirect_pc got=%h exp=200", bus.redirect_pc_o); end
      total++; if (bus.br_cntrl_o !== e) begin bad++; $display("FAIL t1_br got=%h exp=%h", bus.br_cntrl_o, e); end
      total++; if (bus.is_branch_o !== 1'b1) begin bad++; $display("FAIL t1_is_branch got=%b exp=1", bus.is_branch_o); end
      step();
      e = mk_br(32'h0, 32'h0, 1'b1);
      total++; if (bus.redirect_o !== 1'b0) begin bad++; $display("FAIL t1_redirect_pulse got=%b exp=0", bus.redirect_o); end
      total++; if (bus.br_cntrl_o !== e) begin bad++; $display("FAIL t1_br_idle got=%h exp=%h", bus.br_cntrl_o, e); end
      fetch(32'h100); #1;
      total++; if (bus.pred_taken_o !== 1'b1) begin bad++; $display("FAIL t1_refetch_pred got=%b exp=1", bus.pred_taken_o); end
      total++; if (bus.next_pc_o !== 32'h200) begin bad++; $display("FAIL t1_refetch_next got=%h exp=200", bus.next_pc_o); end
      bus.fetch_valid_i = 1'b0; #1;
      total++; if (bus.pred_taken_o !== 1'b0) begin bad++; $display("FAIL pred_gated got=%b exp=0", bus.pred_taken_o); end
      bus.fetch_pc_i = 32'h10C; #1;
      total++; if (bus.btb_raddr_o !== 32'h3) begin bad++; $display("FAIL raddr_10c got=%h exp=3", bus.btb_raddr_o); end
      bus.fetch_pc_i = 32'hFFFF_FFFC; #1;
      total++; if (bus.next_pc_o !== 32'h0) begin bad++; $display("FAIL pc4_wrap got=%h exp=0", bus.next_pc_o); end
      total++; if (bus.btb_raddr_o !== 32'hF) begin bad++; $display("FAIL raddr_top got=%h exp=f", bus.btb_raddr_o); end
      idle_in();
   endtask

   task automatic test_correct();
      br_cntrl_bus_t e;
      fetch(32'h100); step();
      idle_in(); resolve(1'b1, 1'b1, 32'h200); step();
      idle_in();
      e = mk_br(32'h100, 32'h200, 1'b1);
      total++; if (bus.redirect_o !== 1'b0) begin bad++; $display("FAIL t3_redirect got=%b exp=0", bus.redirect_o); end
      total++; if (bus.br_cntrl_o !== e) begin bad++; $display("FAIL t3_br got=%h exp=%h", bus.br_cntrl_o, e); end
      total++; if (bus.is_branch_o !== 1'b1) begin bad++; $display("FAIL t3_is_branch got=%b exp=1", bus.is_branch_o); end
      fetch(32'h300); step();
      idle_in(); resolve(1'b0, 1'b0, 32'h0); step();
      idle_in();
      e = mk_br(32'h0, 32'h0, 1'b1);
      total++; if (bus.redirect_o !== 1'b0) begin bad++; $display("FAIL t3_nb_redirect got=%b exp=0", bus.redirect_o); end
      total++; if (bus.br_cntrl_o !== e) begin bad++; $display("FAIL t3_nb_br got=%h exp=%h", bus.br_cntrl_o, e); end
      total++; if (bus.is_branch_o !== 1'b0) begin bad++; $display("FAIL t3_nb_is_branch got=%b exp=0", bus.is_branch_o); end
   endtask

   task automatic test_not_taken();
      br_cntrl_bus_t e;
      fetch(32'h100); #1;
      total++; if (bus.pred_taken_o !== 1'b1) begin bad++; $display("FAIL t2_pred got=%b exp=1", bus.pred_taken_o); end
      step();
      idle_in(); resolve(1'b1, 1'b0, 32'h0); step();
      idle_in();
      e = mk_br(32'h100, 32'h0, 1'b0);
      total++; if (bus.redirect_o !== 1'b1) begin bad++; $display("FAIL t2_redirect got=%b exp=1", bus.redirect_o); end
      total++; if (bus.redirect_pc_o !== 32'h104) begin bad++; $display("FAIL t2_redirect_pc got=%h exp=104", bus.redirect_pc_o); end
      total++; if (bus.br_cntrl_o !== e) begin bad++; $display("FAIL t2_br got=%h exp=%h", bus.br_cntrl_o, e); end
      total++; if (bus.is_branch_o !== 1'b1) begin bad++; $display("FAIL t2_is_branch got=%b exp=1", bus.is_branch_o); end
      step();
      fetch(32'h100); #1;
      total++; if (bus.pred_taken_o !== 1'b0) begin bad++; $display("FAIL t2_miss got=%b exp=0", bus.pred_taken_o); end
      total++; if (bus.next_pc_o !== 32'h104) begin bad++; $display("FAIL t2_next got=%h exp=104", bus.next_pc_o); end
      idle_in();
   endtask

   task automatic test_alias();
      br_cntrl_bus_t e;
      fetch(32'h100); step();
      idle_in(); resolve(1'b1, 1'b1, 32'h200); step();
      idle_in(); step();
      fetch(32'h100); #1;
      total++; if (bus.pred_taken_o !== 1'b1) begin bad++; $display("FAIL alias_pred got=%b exp=1", bus.pred_taken_o); end
      step();
      idle_in(); resolve(1'b0, 1'b0, 32'h0); step();
      idle_in();
      e = mk_br(32'h100, 32'h0, 1'b0);
      total++; if (bus.redirect_pc_o !== 32'h104) begin bad++; $display("FAIL alias_redirect_pc got=%h exp=104", bus.redirect_pc_o); end
      total++; if (bus.br_cntrl_o !== e) begin bad++; $display("FAIL alias_br got=%h exp=%h", bus.br_cntrl_o, e); end
      total++; if (bus.is_branch_o !== 1'b0) begin bad++; $display("FAIL alias_is_branch got=%b exp=0", bus.is_branch_o); end
      step();
      fetch(32'h100); #1;
      total++; if (bus.pred_taken_o !== 1'b0) begin bad++; $display("FAIL alias_cleared got=%b exp=0", bus.pred_taken_o); end
      idle_in();
   endtask

   task automatic test_full();
      br_cntrl_bus_t e;
      for (int i = 0; i < 4; i++) begin
         fetch(32'h400 + 32'(4 * i));
         step();
      end
      idle_in(); #1;
      total++; if (bus.stall_o !== 1'b1) begin bad++; $display("FAIL full_stall got=%b exp=1", bus.stall_o); end
      fetch(32'h410); step();
      idle_in(); #1;
      total++; if (bus.stall_o !== 1'b1) begin bad++; $display("FAIL full_5th_stall got=%b exp=1", bus.stall_o); end
      fetch(32'h414); resolve(1'b0, 1'b0, 32'h0); step();
      idle_in(); #1;
      total++; if (bus.stall_o !== 1'b1) begin bad++; $display("FAIL full_pushpop got=%b exp=1", bus.stall_o); end
      resolve(1'b0, 1'b0, 32'h0); step();
      total++; if (bus.stall_o !== 1'b0) begin bad++; $display("FAIL full_drain got=%b exp=0", bus.stall_o); end
      step(); step();
      idle_in(); resolve(1'b1, 1'b1, 32'h418); step();
      idle_in();
      e = mk_br(32'h414, 32'h418, 1'b1);
      total++; if (bus.redirect_o !== 1'b0) begin bad++; $display("FAIL full_tail_redirect got=%b exp=0", bus.redirect_o); end
      total++; if (bus.br_cntrl_o !== e) begin bad++; $display("FAIL full_tail_br got=%h exp=%h", bus.br_cntrl_o, e); end
      step();
   endtask

   task automatic test_flush();
      br_cntrl_bus_t e;
      for (int i = 0; i < 4; i++) begin
         fetch(32'h500 + 32'(4 * i));
         step();
      end
      idle_in(); resolve(1'b1, 1'b1, 32'h600); step();
      fetch(32'h700);
      e = mk_br(32'h500, 32'h600, 1'b1);
      total++; if (bus.redirect_o !== 1'b1) begin bad++; $display("FAIL fl_redirect got=%b exp=1", bus.redirect_o); end
      total++; if (bus.redirect_pc_o !== 32'h600) begin bad++; $display("FAIL fl_redirect_pc got=%h exp=600", bus.redirect_pc_o); end
      total++; if (bus.br_cntrl_o !== e) begin bad++; $display("FAIL fl_br got=%h exp=%h", bus.br_cntrl_o, e); end
      step();
      bus.fetch_valid_i = 1'b0;
      e = mk_br(32'h0, 32'h0, 1'b1);
      total++; if (bus.stall_o !== 1'b0) begin bad++; $display("FAIL fl_empty_stall got=%b exp=0", bus.stall_o); end
      total++; if (bus.err_o !== 1'b0) begin bad++; $display("FAIL fl_no_err got=%b exp=0", bus.err_o); end
      total++; if (bus.br_cntrl_o !== e) begin bad++; $display("FAIL fl_dropped_br got=%h exp=%h", bus.br_cntrl_o, e); end
      total++; if (bus.redirect_o !== 1'b0) begin bad++; $display("FAIL fl_one_cycle got=%b exp=0", bus.redirect_o); end
      step();
      idle_in();
      total++; if (bus.err_o !== 1'b1) begin bad++; $display("FAIL fl_err_set got=%b exp=1", bus.err_o); end
      step();
      total++; if (bus.err_o !== 1'b1) begin bad++; $display("FAIL fl_err_sticky got=%b exp=1", bus.err_o); end
   endtask

   task automatic test_reset_mid();
      br_cntrl_bus_t e;
      fetch(32'h500); #1;
      total++; if (bus.pred_taken_o !== 1'b1) begin bad++; $display("FAIL rm_pred got=%b exp=1", bus.pred_taken_o); end
      step();
      fetch(32'h504); resolve(1'b1, 1'b1, 32'h600); step();
      idle_in();
      e = mk_br(32'h500, 32'h600, 1'b1);
      total++; if (bus.br_cntrl_o !== e) begin bad++; $display("FAIL rm_pre_br got=%h exp=%h", bus.br_cntrl_o, e); end
      #2 rst_n = 1'b0;
      #1;
      e = mk_br(32'h0, 32'h0, 1'b1);
      total++; if (bus.br_cntrl_o !== e) begin bad++; $display("FAIL rm_br got=%h exp=%h", bus.br_cntrl_o, e); end
      total++; if (bus.is_branch_o !== 1'b0) begin bad++; $display("FAIL rm_is_branch got=%b exp=0", bus.is_branch_o); end
      total++; if (bus.err_o !== 1'b0) begin bad++; $display("FAIL rm_err got=%b exp=0", bus.err_o); end
      total++; if (bus.redirect_pc_o !== 32'h0) begin bad++; $display("FAIL rm_redirect_pc got=%h exp=0", bus.redirect_pc_o); end
      total++; if (bus.redirect_o !== 1'b0) begin bad++; $display("FAIL rm_redirect got=%b exp=0", bus.redirect_o); end
      total++; if (bus.stall_o !== 1'b0) begin bad++; $display("FAIL rm_stall got=%b exp=0", bus.stall_o); end
      step(); step();
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         total++; if (bus.br_cntrl_o.is_taken !== 1'b1) begin bad++; $display("FAIL idle_is_taken[%0d] got=%b exp=1", i, bus.br_cntrl_o.is_taken); end
      end
      fetch(32'h500); #1;
      total++; if (bus.pred_taken_o !== 1'b1) begin bad++; $display("FAIL rm_btb_kept got=%b exp=1", bus.pred_taken_o); end
      total++; if (bus.next_pc_o !== 32'h600) begin bad++; $display("FAIL rm_btb_next got=%h exp=600", bus.next_pc_o); end
      idle_in(); resolve(1'b0, 1'b0, 32'h0); step();
      idle_in();
      total++; if (bus.err_o !== 1'b1) begin bad++; $display("FAIL rm_fifo_lost got=%b exp=1", bus.err_o); end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_cold_taken();
      test_correct();
      test_not_taken();
      test_alias();
      test_full();
      test_flush();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule
